spi_slave_32: RTL and testbench

- SPI slave, the target end of the 32-bit SPI master that configures the jitter cleaners.
- Receives 32-bit MSB-first words from a master and returns a preloaded 32-bit word on MISO in the same frame.
- Used on target-side firmware that takes configuration over SPI, and as the synthesizable responder in master regression benches.
- All SPI inputs are asynchronous to CLOCK and are oversampled; CLOCK frequency must be at least 8x SCLK.

---
 rtl/spi_slave_32.sv | 173 +++++++++++++++++
 tb/tb_spi_slave_32.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_32.sv
// SPI slave (CPOL=0, CPHA=0): oversamples SCLK/MOSI/CS_N on CLOCK, receives a WIDTH-bit
// MSB-first word and returns a word captured from TX_DATA at frame start.
module spi_slave_32 #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             SPI_SCLK,
  input  logic             SPI_MOSI,
  input  logic             SPI_CS_N,
  output logic             SPI_MISO,
  output logic             SPI_MISO_OE,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             TX_LOADED,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sync_vld_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   armed_q;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // The CS_N chain resets to 1, which is not a real sample of the pin; sync_vld_q
  // keeps ARMED from being set until the chain output reflects the actual input.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sync_vld_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
      sync_vld_q  <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_q | (cs_s & sync_vld_q[SYNC_STAGES-1]);
    end
  end

  state_t            state_q;
  logic [CW-1:0]     count_q;
  logic [WIDTH-1:0]  tx_shift_q;
  logic [WIDTH-1:0]  rx_shift_q;
  logic [WIDTH-1:0]  rx_data_q;
  logic              extra_q;
  logic              miso_q;
  logic              miso_oe_q;
  logic              tx_loaded_q;
  logic              rx_valid_q;
  logic              frame_err_q;
  logic              busy_q;
  logic [WIDTH-1:0]  rx_next;

  assign rx_next = (rx_shift_q << 1) | WIDTH'(mosi_s);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      extra_q     <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      tx_loaded_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tx_loaded_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cs_fall && armed_q) begin
            tx_shift_q  <= TX_DATA;
            miso_q      <= TX_DATA[WIDTH-1];
            tx_loaded_q <= 1'b1;
            count_q     <= '0;
            extra_q     <= 1'b0;
            busy_q      <= 1'b1;
            miso_oe_q   <= 1'b1;
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // CS rise has priority so a coincident SCLK rise drops its bit.
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            miso_q      <= 1'b0;
            count_q     <= '0;
            state_q     <= S_IDLE;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_next;
            count_q    <= count_q + CW'(1);
            if (count_q == LAST_BIT) begin
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              state_q    <= S_FULL;
            end
          end else if (sclk_fall && (count_q != '0)) begin
            tx_shift_q <= tx_shift_q << 1;
            miso_q     <= tx_shift_q[WIDTH-2];
          end
        end
        S_FULL: begin
          if (cs_rise) begin
            frame_err_q <= extra_q;
            extra_q     <= 1'b0;
            busy_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            miso_q      <= 1'b0;
            count_q     <= '0;
            state_q     <= S_IDLE;
          end else if (sclk_rise) begin
            extra_q <= 1'b1;
          end
        end
        default: begin
          busy_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          miso_q    <= 1'b0;
          count_q   <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign SPI_MISO    = miso_q;
  assign SPI_MISO_OE = miso_oe_q;
  assign TX_LOADED   = tx_loaded_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign FRAME_ERR   = frame_err_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_spi_slave_32.sv
// Bench for spi_slave_32: directed and random frames checked against a frame-level model
// (bits sent, bits expected back, pulse counts per frame).
module tb_spi_slave_32;
  localparam int W = 32;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          cs_n = 1'b1;
  logic [W-1:0]  tx_data = '0;
  logic          SPI_MISO, SPI_MISO_OE, TX_LOADED, RX_VALID, FRAME_ERR, BUSY;
  logic [W-1:0]  RX_DATA;

  spi_slave_32 #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_CS_N(cs_n),
    .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .TX_DATA(tx_data),
    .TX_LOADED(TX_LOADED), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int n_txl = 0, n_rxv = 0, n_fe = 0, rxv_cyc = 0;
  logic [W-1:0] rx_q[$];
  always @(negedge CLOCK) begin
    if (!RESET) begin
      if (TX_LOADED) n_txl++;
      if (FRAME_ERR) n_fe++;
      if (RX_VALID) begin
        n_rxv++;
        rx_q.push_back(RX_DATA);
        rxv_cyc = cyc;
      end
    end
  end

  int tests = 0, fails = 0;
  logic [W-1:0] model_rx = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Master side: CS low, n SCLK periods of 8 CLOCKs, MISO sampled at each raw rise.
  task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] word, input int nbits,
                           input int chg_bit, input int gap, output logic [63:0] miso_word,
                           output int rise32_cyc, output logic busy_mid);
    tx_data = tx;
    @(negedge CLOCK);
    cs_n = 1'b0;
    mosi = word[W-1];
    wait_clk(8);
    miso_word = '0;
    rise32_cyc = 0;
    busy_mid = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      if (k == chg_bit) tx_data = '1;
      sclk = 1'b1;
      if (k == W - 1) rise32_cyc = cyc;
      if (k == 0) busy_mid = BUSY & SPI_MISO_OE;
      miso_word = {miso_word[62:0], SPI_MISO};
      wait_clk(4);
      sclk = 1'b0;
      if (k + 1 < W) mosi = word[W-2-k];
      else mosi = 1'($urandom_range(0, 1));
      wait_clk(4);
    end
    cs_n = 1'b1;
    wait_clk(gap);
  endtask

  task automatic do_frame(input string nm, input logic [W-1:0] tx, input logic [W-1:0] word,
                          input int n, input int chg_bit, input int gap);
    int txl0, rxv0, fe0, r32;
    logic [63:0] mw, exp_mw;
    logic bm;
    txl0 = n_txl; rxv0 = n_rxv; fe0 = n_fe;
    run_frame(tx, word, n, chg_bit, gap, mw, r32, bm);
    exp_mw = '0;
    for (int i = 0; i < n; i++) begin
      if (i < W) exp_mw = {exp_mw[62:0], tx[W-1-i]};
      else exp_mw = {exp_mw[62:0], tx[0]};
    end
    if (n >= W) model_rx = word;
    check({nm, "_txl"}, 64'(n_txl - txl0), 64'd1);
    check({nm, "_busy_mid"}, 64'(bm), 64'd1);
    check({nm, "_miso"}, mw, exp_mw);
    check({nm, "_rxv"}, 64'(n_rxv - rxv0), (n >= W) ? 64'd1 : 64'd0);
    check({nm, "_rxdata"}, 64'(RX_DATA), 64'(model_rx));
    if (n >= W) check({nm, "_lat"}, 64'(rxv_cyc - r32), 64'd3);
    if (gap >= 6) begin
      check({nm, "_fe"}, 64'(n_fe - fe0), (n != W) ? 64'd1 : 64'd0);
      check({nm, "_idle"}, {62'd0, BUSY, SPI_MISO_OE}, 64'd0);
    end
  endtask

  initial begin
    int n, sel, txl0, rxv0, fe0;
    logic [W-1:0] tx, wd;

    RESET = 1'b1;
    cs_n = 1'b1;
    wait_clk(3);
    RESET = 1'b0;
    wait_clk(1);
    check("reset_outs", {58'd0, SPI_MISO, SPI_MISO_OE, TX_LOADED, RX_VALID, FRAME_ERR, BUSY}, 64'd0);
    check("reset_rx", 64'(RX_DATA), 64'd0);
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b1; wait_clk(4);
      sclk = 1'b0; wait_clk(4);
    end
    check("cs_high_pulses", 64'(n_txl + n_rxv + n_fe), 64'd0);
    check("cs_high_busy", 64'(BUSY), 64'd0);

    do_frame("basic", 32'hA5A50F0F, 32'h12345678, 32, -1, 10);
    do_frame("short", 32'h0F0F1234, 32'h55AA55AA, 17, -1, 10);
    do_frame("long", 32'h3C3C1234, 32'h9E3779B9, 33, 5, 10);

    txl0 = n_txl; rxv0 = n_rxv; fe0 = n_fe;
    rx_q.delete();
    do_frame("b2b_a", 32'h01020304, 32'hDEADBEEF, 32, -1, 3);
    do_frame("b2b_b", 32'h80000001, 32'h00000001, 32, -1, 10);
    check("b2b_txl", 64'(n_txl - txl0), 64'd2);
    check("b2b_rxv_cnt", 64'(rx_q.size()), 64'd2);
    if (rx_q.size() == 2) begin
      check("b2b_rx0", 64'(rx_q[0]), 64'hDEADBEEF);
      check("b2b_rx1", 64'(rx_q[1]), 64'h00000001);
    end
    check("b2b_fe", 64'(n_fe - fe0), 64'd0);

    // Reset at bit 10 with CS held low; nothing may start until CS cycles high.
    tx_data = 32'h11223344;
    @(negedge CLOCK);
    cs_n = 1'b0;
    wait_clk(8);
    for (int k = 0; k < 10; k++) begin
      sclk = 1'b1; wait_clk(4);
      sclk = 1'b0; mosi = 1'($urandom_range(0, 1)); wait_clk(4);
    end
    RESET = 1'b1;
    #1;
    check("rst_mid_outs", {58'd0, SPI_MISO, SPI_MISO_OE, TX_LOADED, RX_VALID, FRAME_ERR, BUSY}, 64'd0);
    wait_clk(2);
    RESET = 1'b0;
    model_rx = '0;
    txl0 = n_txl; rxv0 = n_rxv; fe0 = n_fe;
    for (int k = 0; k < 34; k++) begin
      sclk = 1'b1; wait_clk(4);
      sclk = 1'b0; mosi = 1'($urandom_range(0, 1)); wait_clk(4);
    end
    check("rst_mid_quiet", 64'(n_txl - txl0 + n_rxv - rxv0 + n_fe - fe0), 64'd0);
    check("rst_mid_busy", {62'd0, BUSY, SPI_MISO_OE}, 64'd0);
    check("rst_mid_rx", 64'(RX_DATA), 64'd0);
    cs_n = 1'b1;
    wait_clk(8);
    check("rst_mid_cs_rise", 64'(n_fe - fe0), 64'd0);
    do_frame("after_rst", 32'h5EED1234, 32'hCAFEF00D, 32, -1, 10);

    for (int f = 0; f < 8; f++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) n = W;
      else if (sel == 1) n = $urandom_range(1, W - 1);
      else n = $urandom_range(W + 1, W + 4);
      tx = $urandom;
      wd = $urandom;
      do_frame("rand", tx, wd, n, $urandom_range(0, 40), 10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
